// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - decode-stage immediate select sequencer with skid-buffered output register
module imm_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [2:0]      imm_sel_o,
  input  logic [XLEN-1:0] imm_ext_i,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_sel,
  output logic            out_has_imm,
  output logic            out_illegal
);

  localparam logic [2:0] SEL_U     = 3'b000;
  localparam logic [2:0] SEL_J     = 3'b001;
  localparam logic [2:0] SEL_I     = 3'b010;
  localparam logic [2:0] SEL_B     = 3'b011;
  localparam logic [2:0] SEL_S     = 3'b100;
  localparam logic [2:0] SEL_SHAMT = 3'b101;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      sel;
    logic            has_imm;
    logic            illegal;
  } entry_t;

  entry_t     o_q;
  entry_t     s_q;
  entry_t     in_e;
  logic [2:0] dec_sel;
  logic       dec_has_imm;
  logic       dec_illegal;
  logic       accept;
  logic       o_free;

  // Classify the incoming instruction format from opcode and funct3
  always_comb begin
    dec_sel     = SEL_U;
    dec_has_imm = 1'b1;
    dec_illegal = 1'b0;
    case (in_inst[6:0])
      OPC_LUI, OPC_AUIPC: dec_sel = SEL_U;
      OPC_JAL:            dec_sel = SEL_J;
      OPC_JALR, OPC_LOAD, OPC_FENCE, OPC_SYSTEM: dec_sel = SEL_I;
      OPC_OPIMM: begin
        if (in_inst[14:12] == 3'b001 || in_inst[14:12] == 3'b101) dec_sel = SEL_SHAMT;
        else                                                       dec_sel = SEL_I;
      end
      OPC_BRANCH: dec_sel = SEL_B;
      OPC_STORE:  dec_sel = SEL_S;
      OPC_OP: begin
        dec_sel     = SEL_I;
        dec_has_imm = 1'b0;
      end
      default: begin
        dec_sel     = SEL_U;
        dec_has_imm = 1'b0;
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign imm_sel_o = dec_sel;

  // Assemble the entry captured on accept; instructions without an immediate carry zero
  always_comb begin
    in_e         = '0;
    in_e.valid   = 1'b1;
    in_e.inst    = in_inst;
    in_e.pc      = in_pc;
    in_e.imm     = dec_has_imm ? imm_ext_i : '0;
    in_e.sel     = dec_sel;
    in_e.has_imm = dec_has_imm;
    in_e.illegal = dec_illegal;
  end

  assign in_ready = !s_q.valid;
  assign accept   = in_valid && in_ready;
  assign o_free   = !o_q.valid || out_ready;

  // Output register plus one-entry skid; skid drains into output before new input is taken
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      o_q <= '0;
      s_q <= '0;
    end else if (flush) begin
      o_q.valid <= 1'b0;
      s_q.valid <= 1'b0;
    end else if (o_free) begin
      if (s_q.valid) begin
        o_q       <= s_q;
        s_q.valid <= 1'b0;
      end else if (accept) begin
        o_q <= in_e;
      end else begin
        o_q.valid <= 1'b0;
      end
    end else if (accept) begin
      s_q <= in_e;
    end
  end

  assign out_valid   = o_q.valid;
  assign out_inst    = o_q.inst;
  assign out_pc      = o_q.pc;
  assign out_imm     = o_q.imm;
  assign out_imm_sel = o_q.sel;
  assign out_has_imm = o_q.has_imm;
  assign out_illegal = o_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed and scoreboard checks for imm_decode_stage
module tb_imm_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [2:0]  imm_sel_o;
  logic [31:0] imm_ext_i;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_imm_sel;
  logic        out_has_imm;
  logic        out_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  imm_decode_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .imm_sel_o(imm_sel_o), .imm_ext_i(imm_ext_i),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_imm(out_imm),
    .out_imm_sel(out_imm_sel), .out_has_imm(out_has_imm), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sign-extension unit in the environment
  function automatic logic [31:0] gen_imm(input logic [31:0] i, input logic [2:0] sel);
    case (sel)
      3'b000:  return {i[31:12], 12'b0};
      3'b001:  return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
      3'b010:  return {{20{i[31]}}, i[31:20]};
      3'b011:  return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
      3'b100:  return {{21{i[31]}}, i[30:25], i[11:7]};
      3'b101:  return {27'b0, i[24:20]};
      default: return 32'h0;
    endcase
  endfunction

  assign imm_ext_i = gen_imm(in_inst, imm_sel_o);

  // Reference for the captured immediate
  function automatic logic [31:0] ref_imm(input logic [31:0] i);
    case (i[6:0])
      7'b0110111, 7'b0010111: return gen_imm(i, 3'b000);
      7'b1101111:             return gen_imm(i, 3'b001);
      7'b1100111, 7'b0000011, 7'b0001111, 7'b1110011: return gen_imm(i, 3'b010);
      7'b0010011: return (i[14:12] == 3'b001 || i[14:12] == 3'b101) ? gen_imm(i, 3'b101) : gen_imm(i, 3'b010);
      7'b1100011: return gen_imm(i, 3'b011);
      7'b0100011: return gen_imm(i, 3'b100);
      default:    return 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_pc = 32'h0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_checks++; if ({out_inst, out_pc, out_imm} !== 96'h0) begin n_fail++; $display("FAIL reset_data got %h %h %h want 0", out_inst, out_pc, out_imm); end
    n_checks++; if ({out_imm_sel, out_has_imm, out_illegal} !== 5'b0) begin n_fail++; $display("FAIL reset_flags got %b %b %b want 0", out_imm_sel, out_has_imm, out_illegal); end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] v [6];
    logic [31:0] e_imm [6];
    logic [2:0]  e_sel [6];
    v = '{32'hFFF00093, 32'h123452B7, 32'h00309093, 32'h0020A423, 32'hFE000EE3, 32'h0000006F};
    e_imm = '{32'hFFFFFFFF, 32'h12345000, 32'h00000003, 32'h00000008, 32'hFFFFFFFC, 32'h00000000};
    e_sel = '{3'b010, 3'b000, 3'b101, 3'b100, 3'b011, 3'b001};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_inst = v[k]; in_pc = 32'h100 + 32'(4 * k);
      step();
      n_checks++; if (out_valid !== 1'b1 || out_inst !== v[k] || out_pc !== 32'h100 + 32'(4 * k))
        begin n_fail++; $display("FAIL stream_beat%0d got v=%0b inst=%h pc=%h want inst=%h", k, out_valid, out_inst, out_pc, v[k]); end
      n_checks++; if (out_imm_sel !== e_sel[k] || out_imm !== e_imm[k] || out_has_imm !== 1'b1 || out_illegal !== 1'b0)
        begin n_fail++; $display("FAIL stream_imm%0d got sel=%b imm=%h want sel=%b imm=%h", k, out_imm_sel, out_imm, e_sel[k], e_imm[k]); end
    end
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_idle got %0b want 0", out_valid); end
  endtask

  task automatic test_no_imm();
    in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h200;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_has_imm !== 1'b0 || out_imm !== 32'h0 || out_imm_sel !== 3'b010 || out_illegal !== 1'b0)
      begin n_fail++; $display("FAIL op_add got v=%0b has=%0b imm=%h sel=%b ill=%0b want 1 0 0 010 0", out_valid, out_has_imm, out_imm, out_imm_sel, out_illegal); end
    in_inst = 32'hABCDE07F; in_pc = 32'h204;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_imm !== 32'h0 || out_imm_sel !== 3'b000 || out_has_imm !== 1'b0)
      begin n_fail++; $display("FAIL illegal got v=%0b ill=%0b imm=%h sel=%b has=%0b want 1 1 0 000 0", out_valid, out_illegal, out_imm, out_imm_sel, out_has_imm); end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100113; in_pc = 32'h300;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_inst !== 32'h00100113 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL bp_a_in_o got v=%0b inst=%h rdy=%0b", out_valid, out_inst, in_ready); end
    in_inst = 32'h00200193; in_pc = 32'h304;
    step();
    n_checks++; if (in_ready !== 1'b0 || out_inst !== 32'h00100113)
      begin n_fail++; $display("FAIL bp_b_in_s got rdy=%0b inst=%h want 0 00100113", in_ready, out_inst); end
    in_inst = 32'h00300213; in_pc = 32'h308;
    step();
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_inst !== 32'h00100113)
      begin n_fail++; $display("FAIL bp_c_held got rdy=%0b v=%0b inst=%h", in_ready, out_valid, out_inst); end
    out_ready = 1'b1;
    step();
    n_checks++; if (out_valid !== 1'b1 || out_inst !== 32'h00200193 || out_pc !== 32'h304 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL bp_b_out got v=%0b inst=%h pc=%h rdy=%0b", out_valid, out_inst, out_pc, in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b1 || out_inst !== 32'h00300213 || out_pc !== 32'h308 || out_imm !== 32'h3)
      begin n_fail++; $display("FAIL bp_c_out got v=%0b inst=%h pc=%h imm=%h", out_valid, out_inst, out_pc, out_imm); end
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00500293; in_pc = 32'h400;
    step();
    in_inst = 32'h00600313; in_pc = 32'h404;
    step();
    in_inst = 32'h00700393; in_pc = 32'h408; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL flush_clear got v=%0b rdy=%0b want 0 1", out_valid, in_ready); end
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++; if (out_valid !== 1'b0)
        begin n_fail++; $display("FAIL flush_leak%0d got v=%0b inst=%h want no beat", k, out_valid, out_inst); end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00800413; in_pc = 32'h500;
    step();
    in_inst = 32'h00900493; in_pc = 32'h504;
    step();
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL rstmid_ctrl got v=%0b rdy=%0b want 0 1", out_valid, in_ready); end
    n_checks++; if ({out_inst, out_pc, out_imm, out_imm_sel, out_has_imm, out_illegal} !== 101'h0)
      begin n_fail++; $display("FAIL rstmid_data got inst=%h pc=%h imm=%h want 0", out_inst, out_pc, out_imm); end
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00A00513; in_pc = 32'h600;
    step();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_inst !== 32'h00A00513 || out_imm !== 32'hA)
      begin n_fail++; $display("FAIL rstmid_first got v=%0b inst=%h imm=%h", out_valid, out_inst, out_imm); end
    step();
  endtask

  task automatic test_random();
    logic [31:0] q_inst [$];
    logic [31:0] q_pc [$];
    logic [6:0]  ops [11];
    logic [31:0] r;
    logic [31:0] pc;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        acc;
    logic        cons;
    int          errs;
    int          budget;
    ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b0000011, 7'b0010011,
            7'b1100011, 7'b0100011, 7'b0110011, 7'b1110011, 7'b1011011};
    pc = 32'h1000;
    errs = 0;
    for (int c = 0; c < 10000; c++) begin
      r = $urandom();
      r[6:0] = ops[$urandom_range(0, 10)];
      in_inst = r; in_pc = pc;
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      acc = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (out_valid && q_inst.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL rand_spurious cycle %0d got inst=%h want no beat", c, out_inst);
      end else if (cons) begin
        e_inst = q_inst.pop_front();
        e_pc = q_pc.pop_front();
        n_checks++;
        if (out_inst !== e_inst || out_pc !== e_pc || out_imm !== ref_imm(e_inst)) begin
          n_fail++; errs++;
          if (errs < 10) $display("FAIL rand_beat cycle %0d got inst=%h pc=%h imm=%h want inst=%h pc=%h imm=%h",
                                  c, out_inst, out_pc, out_imm, e_inst, e_pc, ref_imm(e_inst));
        end
      end
      if (acc) begin
        q_inst.push_back(r);
        q_pc.push_back(pc);
        pc = pc + 32'd4;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    budget = 0;
    while (q_inst.size() != 0 && budget < 10) begin
      if (out_valid) begin
        e_inst = q_inst.pop_front();
        e_pc = q_pc.pop_front();
        n_checks++;
        if (out_inst !== e_inst || out_pc !== e_pc)
          begin n_fail++; $display("FAIL rand_drain got inst=%h pc=%h want inst=%h pc=%h", out_inst, out_pc, e_inst, e_pc); end
      end
      step();
      budget++;
    end
    n_checks++; if (q_inst.size() != 0 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL rand_empty got %0d left v=%0b want 0 0", q_inst.size(), out_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_no_imm();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
